// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: FSM states,
// opcode/func constants, ALU and PC-source codes.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  localparam logic [1:0] ALUC_ADD = 2'b00;
  localparam logic [1:0] ALUC_SUB = 2'b01;
  localparam logic [1:0] ALUC_AND = 2'b10;
  localparam logic [1:0] ALUC_OR  = 2'b11;

  localparam logic [1:0] PCSRC_INC = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  function automatic logic branch_taken(input logic beq, input logic bne, input logic z);
    return (beq & z) | (bne & ~z);
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decode: classifies Op/Func and produces the
// ALU/immediate/destination selects used by the sequencer.
module mc_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic       is_lw,
  output logic       is_sw,
  output logic       is_beq,
  output logic       is_bne,
  output logic       is_j,
  output logic       illegal,
  output logic [1:0] aluc,
  output logic       se,
  output logic       aluqb,
  output logic       regrt
);

  always_comb begin
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_j    = 1'b0;
    illegal = 1'b0;
    aluc    = ALUC_ADD;
    se      = 1'b1;
    aluqb   = 1'b0;
    regrt   = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADD:  aluc = ALUC_ADD;
          FN_SUB:  aluc = ALUC_SUB;
          FN_AND:  aluc = ALUC_AND;
          FN_OR:   aluc = ALUC_OR;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        aluc  = ALUC_ADD;
        aluqb = 1'b1;
        regrt = 1'b1;
      end
      // Logical immediates are zero-extended, everything else sign-extends.
      OP_ANDI: begin
        aluc  = ALUC_AND;
        aluqb = 1'b1;
        regrt = 1'b1;
        se    = 1'b0;
      end
      OP_ORI: begin
        aluc  = ALUC_OR;
        aluqb = 1'b1;
        regrt = 1'b1;
        se    = 1'b0;
      end
      OP_LW: begin
        is_lw = 1'b1;
        aluc  = ALUC_ADD;
        aluqb = 1'b1;
        regrt = 1'b1;
      end
      OP_SW: begin
        is_sw = 1'b1;
        aluc  = ALUC_ADD;
        aluqb = 1'b1;
      end
      OP_BEQ: begin
        is_beq = 1'b1;
        aluc   = ALUC_SUB;
      end
      OP_BNE: begin
        is_bne = 1'b1;
        aluc   = ALUC_SUB;
      end
      OP_J: begin
        is_j = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    // Undecodable instructions drive no selects at all.
    if (illegal) begin
      aluc  = ALUC_ADD;
      se    = 1'b0;
      aluqb = 1'b0;
      regrt = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: IF/ID/EX/MEM/WB FSM with memory handshake,
// datapath select/enable generation and a retired-instruction counter.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic [5:0]  Op,
  input  logic [5:0]  Func,
  input  logic        Z,
  input  logic        Mem_rdy,
  output logic        Mem_req,
  output logic        Iord,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic [1:0]  PCsrc,
  output logic        Regrt,
  output logic        Se,
  output logic        Aluqb,
  output logic [1:0]  Aluc,
  output logic        Wreg,
  output logic        Wmem,
  output logic        Reg2reg,
  output logic        Illegal,
  output logic [31:0] Instret
);

  state_t     state, state_next;
  logic       retire;

  logic       dec_lw, dec_sw, dec_beq, dec_bne, dec_j, dec_illegal;
  logic [1:0] dec_aluc;
  logic       dec_se, dec_aluqb, dec_regrt;

  mc_decode u_decode (
    .op      (Op),
    .func    (Func),
    .is_lw   (dec_lw),
    .is_sw   (dec_sw),
    .is_beq  (dec_beq),
    .is_bne  (dec_bne),
    .is_j    (dec_j),
    .illegal (dec_illegal),
    .aluc    (dec_aluc),
    .se      (dec_se),
    .aluqb   (dec_aluqb),
    .regrt   (dec_regrt)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= S_IF;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Instret <= 32'd0;
    end else if (retire) begin
      Instret <= Instret + 32'd1;
    end
  end

  // Outputs are forced idle while Rst is high so an in-flight write is
  // withdrawn in the same cycle the reset arrives.
  always_comb begin
    state_next = state;
    retire     = 1'b0;
    Mem_req    = 1'b0;
    Iord       = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCsrc      = PCSRC_INC;
    Regrt      = 1'b0;
    Se         = 1'b0;
    Aluqb      = 1'b0;
    Aluc       = ALUC_ADD;
    Wreg       = 1'b0;
    Wmem       = 1'b0;
    Reg2reg    = 1'b0;
    Illegal    = 1'b0;
    if (!Rst) begin
      if (state != S_IF) begin
        Aluc  = dec_aluc;
        Se    = dec_se;
        Aluqb = dec_aluqb;
      end
      case (state)
        S_IF: begin
          Mem_req = 1'b1;
          if (Mem_rdy) begin
            IRWrite    = 1'b1;
            PCWrite    = 1'b1;
            PCsrc      = PCSRC_INC;
            state_next = S_ID;
          end
        end
        S_ID: begin
          if (dec_j) begin
            PCWrite    = 1'b1;
            PCsrc      = PCSRC_JMP;
            retire     = 1'b1;
            state_next = S_IF;
          end else if (dec_illegal) begin
            Illegal    = 1'b1;
            retire     = 1'b1;
            state_next = S_IF;
          end else begin
            state_next = S_EX;
          end
        end
        S_EX: begin
          if (dec_beq || dec_bne) begin
            if (branch_taken(dec_beq, dec_bne, Z)) begin
              PCWrite = 1'b1;
              PCsrc   = PCSRC_BR;
            end
            retire     = 1'b1;
            state_next = S_IF;
          end else if (dec_lw || dec_sw) begin
            state_next = S_MEM;
          end else begin
            state_next = S_WB;
          end
        end
        S_MEM: begin
          Mem_req = 1'b1;
          Iord    = 1'b1;
          if (Mem_rdy) begin
            if (dec_sw) begin
              Wmem       = 1'b1;
              retire     = 1'b1;
              state_next = S_IF;
            end else begin
              state_next = S_WB;
            end
          end
        end
        S_WB: begin
          Wreg       = 1'b1;
          Regrt      = dec_regrt;
          Reg2reg    = dec_lw;
          retire     = 1'b1;
          state_next = S_IF;
        end
        default: state_next = S_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected outputs are queued
// from an instruction model and compared against the DUT each cycle.
module tb_multicycle_ctrl;

  logic        Clk, Rst, Z, Mem_rdy;
  logic [5:0]  Op, Func;
  logic        Mem_req, Iord, IRWrite, PCWrite, Regrt, Se, Aluqb, Wreg, Wmem, Reg2reg, Illegal;
  logic [1:0]  PCsrc, Aluc;
  logic [31:0] Instret;

  multicycle_ctrl dut (
    .Clk(Clk), .Rst(Rst), .Op(Op), .Func(Func), .Z(Z), .Mem_rdy(Mem_rdy),
    .Mem_req(Mem_req), .Iord(Iord), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCsrc(PCsrc), .Regrt(Regrt), .Se(Se), .Aluqb(Aluqb), .Aluc(Aluc),
    .Wreg(Wreg), .Wmem(Wmem), .Reg2reg(Reg2reg), .Illegal(Illegal),
    .Instret(Instret)
  );

  localparam logic [14:0] M_MREQ  = 15'h4000;
  localparam logic [14:0] M_IORD  = 15'h2000;
  localparam logic [14:0] M_IRW   = 15'h1000;
  localparam logic [14:0] M_PCW   = 15'h0800;
  localparam logic [14:0] M_PCSRC = 15'h0600;
  localparam logic [14:0] M_BR    = 15'h0200;
  localparam logic [14:0] M_JMP   = 15'h0400;
  localparam logic [14:0] M_REGRT = 15'h0100;
  localparam logic [14:0] M_SE    = 15'h0080;
  localparam logic [14:0] M_QB    = 15'h0040;
  localparam logic [14:0] M_ALUC  = 15'h0030;
  localparam logic [14:0] M_WREG  = 15'h0008;
  localparam logic [14:0] M_WMEM  = 15'h0004;
  localparam logic [14:0] M_R2R   = 15'h0002;
  localparam logic [14:0] M_ILL   = 15'h0001;
  localparam logic [14:0] EN_MASK = M_MREQ | M_IRW | M_PCW | M_WREG | M_WMEM | M_R2R | M_ILL;

  typedef struct packed {
    logic        rdy;
    logic [14:0] val;
    logic [14:0] care;
    logic        ret;
  } cyc_t;

  cyc_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_instret = 32'd0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (Op=%b Func=%b t=%0t)", tag, got, exp, Op, Func, $time);
    end
  endtask

  function automatic logic [14:0] outs();
    return {Mem_req, Iord, IRWrite, PCWrite, PCsrc, Regrt, Se, Aluqb, Aluc,
            Wreg, Wmem, Reg2reg, Illegal};
  endfunction

  task automatic push(input logic rdy, input logic [14:0] val, input logic [14:0] care,
                      input logic ret);
    cyc_t e;
    e.rdy  = rdy;
    e.val  = val;
    e.care = EN_MASK | care;
    e.ret  = ret;
    sb.push_back(e);
  endtask

  // Drives one instruction and queues the cycle-by-cycle expected outputs.
  task automatic gen(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input int ifw, input int memw);
    logic r, ialu, lw, sw, beq, bne, j, ill, s, qb, taken;
    logic [1:0] ac;
    logic [14:0] exv;
    Op = op; Func = fn; Z = z;
    r    = (op == 6'b000000) &&
           (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 || fn == 6'b100101);
    ialu = (op == 6'b001000) || (op == 6'b001100) || (op == 6'b001101);
    lw   = (op == 6'b100011);
    sw   = (op == 6'b101011);
    beq  = (op == 6'b000100);
    bne  = (op == 6'b000101);
    j    = (op == 6'b000010);
    ill  = !(r || ialu || lw || sw || beq || bne || j);
    ac   = 2'b00;
    if (r && fn == 6'b100010) ac = 2'b01;
    if (r && fn == 6'b100100) ac = 2'b10;
    if (r && fn == 6'b100101) ac = 2'b11;
    if (op == 6'b001100) ac = 2'b10;
    if (op == 6'b001101) ac = 2'b11;
    if (beq || bne) ac = 2'b01;
    s     = !(op == 6'b001100 || op == 6'b001101);
    qb    = ialu || lw || sw;
    taken = (beq && z) || (bne && !z);

    for (int i = 0; i < ifw; i++) push(1'b0, M_MREQ, M_IORD, 1'b0);
    push(1'b1, M_MREQ | M_IRW | M_PCW, M_IORD | M_PCSRC, 1'b0);
    if (j) begin
      push(1'($urandom_range(0, 1)), M_PCW | M_JMP, M_PCSRC, 1'b1);
      return;
    end
    if (ill) begin
      push(1'($urandom_range(0, 1)), M_ILL, 15'h0, 1'b1);
      return;
    end
    push(1'($urandom_range(0, 1)), 15'h0, 15'h0, 1'b0);
    exv = (s ? M_SE : 15'h0) | (qb ? M_QB : 15'h0) | (15'(ac) << 4);
    if (beq || bne) begin
      push(1'($urandom_range(0, 1)), exv | (taken ? (M_PCW | M_BR) : 15'h0),
           M_SE | M_QB | M_ALUC | (taken ? M_PCSRC : 15'h0), 1'b1);
      return;
    end
    push(1'($urandom_range(0, 1)), exv, M_SE | M_QB | M_ALUC, 1'b0);
    if (lw || sw) begin
      for (int i = 0; i < memw; i++) push(1'b0, M_MREQ | M_IORD, M_IORD, 1'b0);
      push(1'b1, M_MREQ | M_IORD | (sw ? M_WMEM : 15'h0), M_IORD, sw);
      if (sw) return;
    end
    push(1'($urandom_range(0, 1)), M_WREG | ((ialu || lw) ? M_REGRT : 15'h0) |
         (lw ? M_R2R : 15'h0), M_REGRT, 1'b1);
  endtask

  task automatic run(input int keep);
    cyc_t e;
    while (sb.size() > keep) begin
      e = sb.pop_front();
      Mem_rdy = e.rdy;
      @(negedge Clk);
      check_val("outs", 32'(outs() & e.care), 32'(e.val & e.care));
      check_val("instret", Instret, exp_instret);
      @(posedge Clk);
      #1;
      if (e.ret) exp_instret = exp_instret + 32'd1;
    end
  endtask

  logic [5:0] op_tab [12] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b001000, 6'b001100,
                             6'b001101, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010};
  logic [5:0] fn_tab [4]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101};

  initial begin
    cyc_t e;
    int   k;
    Rst = 1'b1; Op = 6'd0; Func = 6'd0; Z = 1'b0; Mem_rdy = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check_val("reset_outs", 32'(outs()), 32'd0);
    check_val("reset_instret", Instret, 32'd0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;

    gen(6'b000000, 6'b100000, 1'b0, 0, 0); run(0);   // add, 4 cycles
    gen(6'b000000, 6'b100010, 1'b1, 1, 0); run(0);   // sub
    gen(6'b000000, 6'b100100, 1'b0, 0, 0); run(0);   // and
    gen(6'b000000, 6'b100101, 1'b0, 0, 0); run(0);   // or
    gen(6'b001000, 6'b000000, 1'b0, 0, 0); run(0);   // addi
    gen(6'b001100, 6'b111111, 1'b0, 0, 0); run(0);   // andi
    gen(6'b001101, 6'b000000, 1'b1, 0, 0); run(0);   // ori
    gen(6'b100011, 6'b000000, 1'b0, 2, 3); run(0);   // lw, 10 cycles
    gen(6'b100011, 6'b000000, 1'b0, 0, 0); run(0);   // lw, 5 cycles
    gen(6'b101011, 6'b000000, 1'b0, 0, 0); run(0);   // sw
    gen(6'b101011, 6'b000000, 1'b1, 1, 2); run(0);   // sw with waits
    gen(6'b000100, 6'b000000, 1'b1, 0, 0); run(0);   // beq taken
    gen(6'b000100, 6'b000000, 1'b0, 0, 0); run(0);   // beq not taken
    gen(6'b000101, 6'b000000, 1'b0, 0, 0); run(0);   // bne taken
    gen(6'b000101, 6'b000000, 1'b1, 0, 0); run(0);   // bne not taken
    gen(6'b000010, 6'b000000, 1'b0, 0, 0); run(0);   // j
    gen(6'b111111, 6'b000000, 1'b0, 0, 0); run(0);   // illegal opcode
    gen(6'b000000, 6'b000000, 1'b0, 0, 0); run(0);   // illegal func

    for (int i = 0; i < 20; i++) begin
      k = $urandom_range(0, 11);
      gen(op_tab[k], fn_tab[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
          $urandom_range(0, 3), $urandom_range(0, 3));
      run(0);
    end

    // Reset in the middle of a completing store.
    gen(6'b101011, 6'b000000, 1'b0, 0, 0);
    run(1);
    e = sb.pop_front();
    Mem_rdy = 1'b1;
    @(negedge Clk);
    check_val("sw_wmem_before_rst", 32'(Wmem), 32'd1);
    Rst = 1'b1;
    #1;
    check_val("rst_wmem", 32'(Wmem), 32'd0);
    check_val("rst_mem_req", 32'(Mem_req), 32'd0);
    check_val("rst_instret", Instret, 32'd0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    exp_instret = 32'd0;
    gen(6'b000010, 6'b000000, 1'b0, 0, 0); run(0);
    gen(6'b000000, 6'b100000, 1'b0, 0, 0); run(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
